sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl.sv | 135 +++++++++++++
 tb/tb_sram_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// SRAM controller with banked addressing and a read-only ROM overlay window.
// Strobes, address and read data are registered alongside the FSM state.
module sram_ctrl #(
  parameter int CPU_AW     = 16,
  parameter int SRAM_AW    = 18,
  parameter int DW         = 8,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 3,
  parameter int ROM_EN     = 1,
  parameter int ROM_BASE   = 0,
  parameter int ROM_SIZE   = 256
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_cs,
  input  logic                      i_we,
  input  logic [CPU_AW-1:0]         i_addr,
  input  logic [SRAM_AW-CPU_AW-1:0] i_bank,
  input  logic [DW-1:0]             i_dat,
  output logic [DW-1:0]             o_dat,
  output logic                      o_ack,
  output logic [SRAM_AW-1:0]        o_sram_addr,
  output logic [DW-1:0]             o_sram_dat,
  output logic                      o_sram_dat_oe,
  input  logic [DW-1:0]             i_sram_dat,
  output logic                      o_sram_cs_n,
  output logic                      o_sram_oe_n,
  output logic                      o_sram_we_n,
  output logic [$clog2(ROM_SIZE)-1:0] o_rom_addr,
  input  logic [DW-1:0]             i_rom_dat
);

  localparam int RAW = $clog2(ROM_SIZE);
  localparam logic [3:0] RD_W = 4'(READ_WAIT);
  localparam logic [3:0] WR_W = 4'(WRITE_WAIT);
  localparam logic [31:0] ROM_LO = 32'(ROM_BASE);
  localparam logic [31:0] ROM_HI = 32'(ROM_BASE + ROM_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    ROM,
    ACK
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_w;
  logic        rom_hit;

  assign addr_w  = 32'(i_addr);
  assign rom_hit = (ROM_EN != 0) && !i_we &&
                   (addr_w >= ROM_LO) && (addr_w < ROM_HI);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      we_q          <= 1'b0;
      o_ack         <= 1'b0;
      o_dat         <= '0;
      o_sram_addr   <= '0;
      o_sram_dat    <= '0;
      o_sram_dat_oe <= 1'b0;
      o_sram_cs_n   <= 1'b1;
      o_sram_oe_n   <= 1'b1;
      o_sram_we_n   <= 1'b1;
      o_rom_addr    <= '0;
    end else begin
      o_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_cs) begin
            o_sram_addr <= {i_bank, i_addr};
            o_sram_dat  <= i_dat;
            we_q        <= i_we;
            if (rom_hit) begin
              state      <= ROM;
              o_rom_addr <= RAW'(i_addr - CPU_AW'(ROM_BASE));
            end else begin
              state         <= SETUP;
              o_sram_cs_n   <= 1'b0;
              o_sram_oe_n   <= i_we;
              o_sram_dat_oe <= i_we;
            end
          end
        end
        SETUP: begin
          state       <= ACCESS;
          cnt         <= we_q ? WR_W : RD_W;
          o_sram_we_n <= !we_q;
        end
        ACCESS: begin
          if (cnt == 4'd1) begin
            cnt <= 4'd0;
            if (we_q) begin
              state       <= HOLD;
              o_sram_we_n <= 1'b1;
            end else begin
              // last strobe cycle: SRAM data is settled here
              state       <= ACK;
              o_dat       <= i_sram_dat;
              o_ack       <= 1'b1;
              o_sram_cs_n <= 1'b1;
              o_sram_oe_n <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          state         <= ACK;
          o_ack         <= 1'b1;
          o_sram_cs_n   <= 1'b1;
          o_sram_dat_oe <= 1'b0;
        end
        ROM: begin
          state <= ACK;
          o_dat <= i_rom_dat;
          o_ack <= 1'b1;
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a per-cycle timeline model and SRAM/ROM models.
// Expected strobe windows come from access kind and relative cycle number.
module tb_sram_ctrl;

  localparam int RW  = 2;
  localparam int WW  = 3;
  localparam int BIG = 1 << 30;

  typedef enum int {K_NONE, K_RD, K_WR, K_ROM} kind_t;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_cs;
  logic        i_we;
  logic [15:0] i_addr;
  logic [1:0]  i_bank;
  logic [7:0]  i_dat;
  logic [7:0]  o_dat;
  logic        o_ack;
  logic [17:0] o_sram_addr;
  logic [7:0]  o_sram_dat;
  logic        o_sram_dat_oe;
  logic [7:0]  i_sram_dat;
  logic        o_sram_cs_n;
  logic        o_sram_oe_n;
  logic        o_sram_we_n;
  logic [7:0]  o_rom_addr;
  logic [7:0]  i_rom_dat;

  sram_ctrl dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_cs          (i_cs),
    .i_we          (i_we),
    .i_addr        (i_addr),
    .i_bank        (i_bank),
    .i_dat         (i_dat),
    .o_dat         (o_dat),
    .o_ack         (o_ack),
    .o_sram_addr   (o_sram_addr),
    .o_sram_dat    (o_sram_dat),
    .o_sram_dat_oe (o_sram_dat_oe),
    .i_sram_dat    (i_sram_dat),
    .o_sram_cs_n   (o_sram_cs_n),
    .o_sram_oe_n   (o_sram_oe_n),
    .o_sram_we_n   (o_sram_we_n),
    .o_rom_addr    (o_rom_addr),
    .i_rom_dat     (i_rom_dat)
  );

  always #5 i_clk = ~i_clk;

  logic [7:0] mem [0:262143];

  assign i_sram_dat = (!o_sram_oe_n && !o_sram_cs_n) ?
                      mem[o_sram_addr] : 8'hEE;
  assign i_rom_dat  = o_rom_addr ^ 8'hD3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  kind_t       kind = K_NONE;
  int          acc  = 0;
  int          len  = 0;
  int          kill = BIG;
  logic [17:0] cur_addr;
  logic [7:0]  cur_wdat;
  logic [7:0]  cur_dat;
  logic [7:0]  last_rd = 8'h00;

  int          cs_cnt, oe_cnt, we_cnt;
  int          ack_cnt = 0;
  logic [17:0] seen_addr;
  logic [7:0]  rom_seen;

  bit          pend = 1'b0;
  logic [17:0] pend_a;
  logic [7:0]  pend_d;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // SRAM device model: a write lands when we_n rises with cs_n still low
  always @(negedge i_clk) begin
    if (o_sram_cs_n) begin
      pend = 1'b0;
    end else if (!o_sram_we_n) begin
      pend   = 1'b1;
      pend_a = o_sram_addr;
      pend_d = o_sram_dat;
    end else if (pend) begin
      mem[pend_a] = pend_d;
      pend = 1'b0;
    end
  end

  always @(negedge i_clk) begin
    int   r;
    bit   live;
    bit   rd_done;
    logic e_ack, e_cs, e_oe, e_we, e_doe;
    logic [7:0] e_dat;
    if (chk_en) begin
      r       = cyc - acc;
      live    = (kind != K_NONE) && (cyc < kill) && r >= 0 && r < len;
      rd_done = (kind == K_RD || kind == K_ROM) && (cyc < kill) &&
                r >= len - 1;
      e_ack = live && r == len - 1;
      e_cs  = !(live && kind != K_ROM && r <= len - 2);
      e_oe  = !(live && kind == K_RD && r <= len - 2);
      e_we  = !(live && kind == K_WR && r >= 1 && r <= WW);
      e_doe = live && kind == K_WR && r <= len - 2;
      e_dat = rd_done ? cur_dat : last_rd;
      chk("ack", 32'(o_ack), 32'(e_ack));
      chk("cs_n", 32'(o_sram_cs_n), 32'(e_cs));
      chk("oe_n", 32'(o_sram_oe_n), 32'(e_oe));
      chk("we_n", 32'(o_sram_we_n), 32'(e_we));
      chk("dat_oe", 32'(o_sram_dat_oe), 32'(e_doe));
      chk("o_dat", 32'(o_dat), 32'(e_dat));
      chk("we_oe_excl", 32'(!o_sram_we_n && !o_sram_oe_n), 32'd0);
      chk("oe_doe_excl", 32'(!o_sram_oe_n && o_sram_dat_oe), 32'd0);
      if (!e_cs)
        chk("sram_addr", 32'(o_sram_addr), 32'(cur_addr));
      if (e_doe)
        chk("sram_dat", 32'(o_sram_dat), 32'(cur_wdat));
      if (live && kind == K_ROM && r == 0) begin
        chk("rom_addr", 32'(o_rom_addr), 32'(cur_addr[7:0]));
        rom_seen = o_rom_addr;
      end
      if (!o_sram_cs_n) begin
        cs_cnt++;
        seen_addr = o_sram_addr;
      end
      if (!o_sram_oe_n) oe_cnt++;
      if (!o_sram_we_n) we_cnt++;
      if (o_ack) ack_cnt++;
    end
  end

  task automatic start(input bit we, input logic [1:0] bank,
                       input logic [15:0] addr, input logic [7:0] dat,
                       input int lead);
    bit rom;
    rom      = !we && addr < 16'h0100;
    i_cs     = 1'b1;
    i_we     = we;
    i_bank   = bank;
    i_addr   = addr;
    i_dat    = dat;
    acc      = cyc + lead;
    kill     = BIG;
    cur_addr = {bank, addr};
    cur_wdat = dat;
    cs_cnt   = 0;
    oe_cnt   = 0;
    we_cnt   = 0;
    kind     = we ? K_WR : (rom ? K_ROM : K_RD);
    len      = rom ? 2 : (we ? 3 + WW : 2 + RW);
    cur_dat  = rom ? (addr[7:0] ^ 8'hD3) : mem[{bank, addr}];
  endtask

  task automatic run(input bit we, input logic [1:0] bank,
                     input logic [15:0] addr, input logic [7:0] dat,
                     input int lead, input bit keep, input bit wiggle,
                     output int lat);
    bit found;
    start(we, bank, addr, dat, lead);
    found = 1'b0;
    lat   = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      #2;
      if (wiggle && i == lead - 1) begin
        i_cs   = 1'b0;
        i_addr = ~addr;
        i_bank = ~bank;
        i_dat  = ~dat;
      end
      if (o_ack) begin
        found = 1'b1;
        lat   = cyc - acc + 1;
        break;
      end
    end
    chk("ack_seen", 32'(found), 32'd1);
    if (!keep) i_cs = 1'b0;
    if (kind != K_WR) last_rd = cur_dat;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
    #2;
  endtask

  initial begin
    int lat;
    int a0;
    i_reset_n = 1'b0;
    i_cs      = 1'b0;
    i_we      = 1'b0;
    i_addr    = '0;
    i_bank    = '0;
    i_dat     = '0;
    mem[18'h11234] = 8'hA5;
    mem[18'h00100] = 8'h5A;
    mem[18'h00101] = 8'h96;
    mem[18'h22222] = 8'h4D;
    idle(3);
    chk("rst_ack", 32'(o_ack), 32'd0);
    chk("rst_dat", 32'(o_dat), 32'd0);
    chk("rst_addr", 32'(o_sram_addr), 32'd0);
    chk("rst_rom", 32'(o_rom_addr), 32'd0);
    chk("rst_strb", 32'({o_sram_cs_n, o_sram_oe_n, o_sram_we_n}), 32'd7);
    chk("rst_doe", 32'(o_sram_dat_oe), 32'd0);
    i_reset_n = 1'b1;
    chk_en    = 1'b1;
    idle(1);

    run(1'b0, 2'b01, 16'h1234, 8'h00, 1, 1'b0, 1'b0, lat);
    chk("rd_lat", 32'(lat), 32'd4);
    chk("rd_dat", 32'(o_dat), 32'hA5);
    chk("rd_oe_cnt", 32'(oe_cnt), 32'd3);
    chk("rd_addr", 32'(seen_addr), 32'h11234);
    idle(1);

    run(1'b1, 2'b00, 16'h8000, 8'h3C, 1, 1'b0, 1'b0, lat);
    chk("wr_lat", 32'(lat), 32'd6);
    chk("wr_we_cnt", 32'(we_cnt), 32'd3);
    chk("wr_oe_cnt", 32'(oe_cnt), 32'd0);
    chk("wr_mem", 32'(mem[18'h08000]), 32'h3C);
    idle(1);

    run(1'b0, 2'b00, 16'h0010, 8'h00, 1, 1'b0, 1'b0, lat);
    chk("rom_lat", 32'(lat), 32'd2);
    chk("rom_dat", 32'(o_dat), 32'hC3);
    chk("rom_cs_cnt", 32'(cs_cnt), 32'd0);
    chk("rom_off", 32'(rom_seen), 32'h10);
    idle(1);

    run(1'b1, 2'b00, 16'h0010, 8'h77, 1, 1'b0, 1'b0, lat);
    chk("shadow_lat", 32'(lat), 32'd6);
    chk("shadow_mem", 32'(mem[18'h00010]), 32'h77);
    chk("shadow_cs", 32'(cs_cnt), 32'd5);
    idle(1);

    a0 = ack_cnt;
    run(1'b0, 2'b00, 16'h0100, 8'h00, 1, 1'b1, 1'b0, lat);
    chk("b2b_lat0", 32'(lat), 32'd4);
    chk("b2b_dat0", 32'(o_dat), 32'h5A);
    run(1'b0, 2'b00, 16'h0101, 8'h00, 2, 1'b0, 1'b0, lat);
    chk("b2b_lat1", 32'(lat), 32'd4);
    chk("b2b_dat1", 32'(o_dat), 32'h96);
    chk("b2b_acks", 32'(ack_cnt - a0), 32'd2);
    idle(1);

    run(1'b0, 2'b10, 16'h2222, 8'h00, 1, 1'b0, 1'b1, lat);
    chk("wig_rd_dat", 32'(o_dat), 32'h4D);
    chk("wig_rd_addr", 32'(seen_addr), 32'h22222);
    idle(1);

    run(1'b1, 2'b11, 16'hABCD, 8'hE1, 1, 1'b0, 1'b1, lat);
    chk("wig_wr_lat", 32'(lat), 32'd6);
    chk("wig_wr_mem", 32'(mem[18'h3ABCD]), 32'hE1);
    chk("wig_wr_other", 32'(mem[18'h05432]), 32'h00);
    idle(1);

    a0 = ack_cnt;
    start(1'b1, 2'b00, 16'h4444, 8'h99, 1);
    idle(3);
    i_reset_n = 1'b0;
    i_cs      = 1'b0;
    kill      = cyc + 1;
    last_rd   = 8'h00;
    idle(1);
    chk("abort_we_n", 32'(o_sram_we_n), 32'd1);
    chk("abort_cs_n", 32'(o_sram_cs_n), 32'd1);
    chk("abort_dat", 32'(o_dat), 32'h00);
    i_reset_n = 1'b1;
    run(1'b0, 2'b01, 16'h1234, 8'h00, 1, 1'b0, 1'b0, lat);
    chk("post_rst_lat", 32'(lat), 32'd4);
    chk("post_rst_dat", 32'(o_dat), 32'hA5);
    chk("abort_acks", 32'(ack_cnt - a0), 32'd1);
    chk("abort_mem", 32'(mem[18'h04444]), 32'h00);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
